// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared widths, constants and FSM encoding for the register file
package regfile_wb_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_CNT_W    = 32;

    localparam logic [RF_DATA_W-1:0] RF_ZERO_WORD = '0;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_wb_if.sv
// rtl/regfile_wb_if.sv - write-back / ID-read bundle between the pipeline and the register file
interface regfile_wb_if
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) ();

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic                re1;
    logic [ADDR_W-1:0]   raddr1;
    logic [DATA_W-1:0]   rdata1;
    logic                re2;
    logic [ADDR_W-1:0]   raddr2;
    logic [DATA_W-1:0]   rdata2;
    logic                busy;
    logic [RF_CNT_W-1:0] wr_cnt;

    // pipeline side: MEM/WB writes, ID reads
    modport master (
        output we, waddr, wdata,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, busy, wr_cnt
    );

    // register file side
    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2, busy, wr_cnt
    );

endinterface

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port with priority mux; same-cycle bypass under REGFILE_BYPASS_EN
module regfile_rd_port
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              rst,
    input  logic              busy,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] rdata
`ifdef REGFILE_BYPASS_EN
    ,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
`endif
);

    // Priority read mux. RUN is implied by busy==0, so the bypass term
    // only needs the write-side qualifiers.
    always_comb begin
        rdata = '0;
        if (rst || busy) begin
            rdata = '0;
        end else if (!re) begin
            rdata = '0;
        end else if (raddr == '0) begin
            rdata = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (we && (waddr != '0) && (raddr == waddr)) begin
            rdata = wdata;
`endif
        end else begin
            rdata = mem_data;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - architectural register file with reset clear sequencer; optional bypass via REGFILE_BYPASS_EN
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic         clk,
    input  logic         rst,
    regfile_wb_if.slave  bus
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    rf_state_e           state;
    logic [ADDR_W-1:0]   clr_ptr;
    logic                busy_q;
    logic [RF_CNT_W-1:0] wr_cnt_q;
    logic                commit;
    logic [DATA_W-1:0]   mem1;
    logic [DATA_W-1:0]   mem2;

    // a write commits only in RUN and never to $0
    assign commit = (state == RF_RUN) && bus.we && (bus.waddr != '0);

    // clear sequencer, storage writes and commit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RF_CLEAR;
            clr_ptr  <= '0;
            busy_q   <= 1'b1;
            wr_cnt_q <= '0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    regs[clr_ptr] <= '0;
                    clr_ptr       <= clr_ptr + 1'b1;
                    if (clr_ptr == ADDR_W'(NUM_REGS - 1)) begin
                        state  <= RF_RUN;
                        busy_q <= 1'b0;
                    end
                end
                RF_RUN: begin
                    if (commit) begin
                        regs[bus.waddr] <= bus.wdata;
                        wr_cnt_q        <= wr_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state  <= RF_CLEAR;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign mem1       = regs[bus.raddr1];
    assign mem2       = regs[bus.raddr2];
    assign bus.busy   = busy_q;
    assign bus.wr_cnt = wr_cnt_q;

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd1 (
        .rst      (rst),
        .busy     (busy_q),
        .re       (bus.re1),
        .raddr    (bus.raddr1),
        .mem_data (mem1),
        .rdata    (bus.rdata1)
`ifdef REGFILE_BYPASS_EN
        ,
        .we       (bus.we),
        .waddr    (bus.waddr),
        .wdata    (bus.wdata)
`endif
    );

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd2 (
        .rst      (rst),
        .busy     (busy_q),
        .re       (bus.re2),
        .raddr    (bus.raddr2),
        .mem_data (mem2),
        .rdata    (bus.rdata2)
`ifdef REGFILE_BYPASS_EN
        ,
        .we       (bus.we),
        .waddr    (bus.waddr),
        .wdata    (bus.wdata)
`endif
    );

endmodule
